uart_ctrl: RTL and testbench

UART_CTRL -- requirements
Module: uart_ctrl

---
 rtl/uart_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_uart_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ctrl.sv
// uart_ctrl: bus-mapped controller with TX/RX byte FIFOs in front of a UART core.
// Optional CTRL register and level interrupt are built when UART_CTRL_IRQ_EN is defined.
module uart_ctrl #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned AW         = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sel,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          ready,
  output logic          uart_transmit,
  output logic [7:0]    uart_tx_byte,
  input  logic          uart_is_transmitting,
  input  logic          uart_received,
  input  logic [7:0]    uart_rx_byte,
  input  logic          uart_recv_error
`ifdef UART_CTRL_IRQ_EN
  ,
  output logic          irq
`endif
);

  localparam int unsigned IW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = IW + 1;
  localparam int unsigned RW = AW - 2;

  localparam logic [RW-1:0] REG_DATA   = RW'(0);
  localparam logic [RW-1:0] REG_STATUS = RW'(1);
  localparam logic [RW-1:0] REG_CTRL   = RW'(2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } tx_state_t;

  tx_state_t state_q, state_d;

  // Bus decode: a held sel is ignored during the ready cycle.
  logic          acc, wr_acc, rd_acc;
  logic [RW-1:0] reg_idx;
  logic          data_wr, data_rd, status_wr;

  assign acc       = sel & ~ready;
  assign wr_acc    = acc & we;
  assign rd_acc    = acc & ~we;
  assign reg_idx   = addr[AW-1:2];
  assign data_wr   = wr_acc & (reg_idx == REG_DATA);
  assign data_rd   = rd_acc & (reg_idx == REG_DATA);
  assign status_wr = wr_acc & (reg_idx == REG_STATUS);

  // TX FIFO
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wp, tx_rp;
  logic          tx_empty, tx_full, tx_push, tx_pop, tx_ovf_set, tx_busy;
  logic [7:0]    tx_head;

  assign tx_empty   = (tx_wp == tx_rp);
  assign tx_full    = (tx_wp[PW-1] != tx_rp[PW-1]) && (tx_wp[IW-1:0] == tx_rp[IW-1:0]);
  assign tx_head    = tx_mem[tx_rp[IW-1:0]];
  assign tx_pop     = (state_q == S_ISSUE) && !tx_empty;
  assign tx_push    = data_wr && (!tx_full || tx_pop);
  assign tx_ovf_set = data_wr && tx_full && !tx_pop;
  assign tx_busy    = !tx_empty || (state_q != S_IDLE);

  // RX FIFO
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wp, rx_rp;
  logic          rx_empty, rx_full, rx_avail, rx_push, rx_pop, rx_ovr_set;
  logic [7:0]    rx_head;

  assign rx_empty   = (rx_wp == rx_rp);
  assign rx_full    = (rx_wp[PW-1] != rx_rp[PW-1]) && (rx_wp[IW-1:0] == rx_rp[IW-1:0]);
  assign rx_avail   = !rx_empty;
  assign rx_head    = rx_mem[rx_rp[IW-1:0]];
  assign rx_pop     = data_rd && !rx_empty;
  assign rx_push    = uart_received && (!rx_full || rx_pop);
  assign rx_ovr_set = uart_received && rx_full && !rx_pop;

  logic rx_ovr, rx_err, tx_ovf;

`ifdef UART_CTRL_IRQ_EN
  logic [2:0] ctrl_q;
  logic       ctrl_wr;

  assign ctrl_wr = wr_acc & (reg_idx == REG_CTRL);
`endif

  // Read mux, sampled into rdata on the accepting cycle
  logic [31:0] rd_val;

  always_comb begin
    rd_val = 32'h0;
    case (reg_idx)
      REG_DATA:   rd_val = rx_empty ? 32'h0 : {24'h0, rx_head};
      REG_STATUS: rd_val = {24'h0, tx_busy, tx_ovf, rx_err, rx_ovr,
                            rx_full, rx_avail, tx_empty, tx_full};
`ifdef UART_CTRL_IRQ_EN
      REG_CTRL:   rd_val = {29'h0, ctrl_q};
`else
      REG_CTRL:   rd_val = 32'h0;
`endif
      default:    rd_val = 32'h0;
    endcase
  end

  // TX FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // TX FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (!tx_empty && !uart_is_transmitting) state_d = S_ISSUE;
      S_ISSUE:     state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: if (uart_is_transmitting) state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (!uart_is_transmitting) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Registered bus response, pointers, sticky flags and UART strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      ready         <= 1'b0;
      rdata         <= 32'h0;
      tx_wp         <= '0;
      tx_rp         <= '0;
      rx_wp         <= '0;
      rx_rp         <= '0;
      rx_ovr        <= 1'b0;
      rx_err        <= 1'b0;
      tx_ovf        <= 1'b0;
      uart_transmit <= 1'b0;
      uart_tx_byte  <= 8'h00;
    end else begin
      ready <= acc;
      rdata <= rd_acc ? rd_val : 32'h0;
      if (tx_push) tx_wp <= tx_wp + PW'(1);
      if (tx_pop)  tx_rp <= tx_rp + PW'(1);
      if (rx_push) rx_wp <= rx_wp + PW'(1);
      if (rx_pop)  rx_rp <= rx_rp + PW'(1);
      // A set in the same cycle as a write-1-to-clear keeps the bit set
      rx_ovr <= (rx_ovr & ~(status_wr & wdata[4])) | rx_ovr_set;
      rx_err <= (rx_err & ~(status_wr & wdata[5])) | uart_recv_error;
      tx_ovf <= (tx_ovf & ~(status_wr & wdata[6])) | tx_ovf_set;
      // Head is stable while entering ISSUE since only ISSUE pops
      uart_transmit <= (state_d == S_ISSUE);
      uart_tx_byte  <= (state_d == S_ISSUE) ? tx_head : 8'h00;
    end
  end

  // FIFO storage needs no reset; pointers define validity
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[IW-1:0]] <= wdata[7:0];
    if (rx_push) rx_mem[rx_wp[IW-1:0]] <= uart_rx_byte;
  end

`ifdef UART_CTRL_IRQ_EN
  // CTRL: [0] rx_ie, [1] tx_ie, [2] err_ie
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= 3'b000;
      irq    <= 1'b0;
    end else begin
      if (ctrl_wr) ctrl_q <= wdata[2:0];
      irq <= (ctrl_q[0] & rx_avail) |
             (ctrl_q[1] & tx_empty & ~tx_busy) |
             (ctrl_q[2] & (rx_ovr | rx_err | tx_ovf));
    end
  end
`endif

  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31:8]};

endmodule

// File: tb/tb_uart_ctrl.sv
// Scoreboard bench for uart_ctrl: queue-based model of the FIFOs and sticky flags,
// a behavioural UART core, directed corner cases and randomized RX/TX traffic.
`timescale 1ns/1ps
module tb_uart_ctrl;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 4;
  localparam logic [AW-1:0] A_DATA   = 4'h0;
  localparam logic [AW-1:0] A_STATUS = 4'h4;
  localparam logic [AW-1:0] A_CTRL   = 4'h8;
  localparam logic [AW-1:0] A_NONE   = 4'hC;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sel = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [31:0]   wdata = 32'h0;
  logic [31:0]   rdata;
  logic          ready;
  logic          uart_transmit;
  logic [7:0]    uart_tx_byte;
  logic          uart_is_transmitting = 1'b0;
  logic          uart_received = 1'b0;
  logic [7:0]    uart_rx_byte = 8'h00;
  logic          uart_recv_error = 1'b0;
`ifdef UART_CTRL_IRQ_EN
  logic          irq;
`endif

  uart_ctrl #(.FIFO_DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk),
    .rst(rst),
    .sel(sel),
    .we(we),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .ready(ready),
    .uart_transmit(uart_transmit),
    .uart_tx_byte(uart_tx_byte),
    .uart_is_transmitting(uart_is_transmitting),
    .uart_received(uart_received),
    .uart_rx_byte(uart_rx_byte),
    .uart_recv_error(uart_recv_error)
`ifdef UART_CTRL_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: plain queues and flags
  logic [7:0] rx_q[$];
  logic [7:0] tx_exp_q[$];
  bit         m_ovr = 1'b0, m_err = 1'b0, m_ovf = 1'b0;
  logic [2:0] m_ctrl = 3'b000;

  typedef struct {
    bit          is_rd;
    logic [31:0] val;
  } bus_exp_t;
  bus_exp_t exp_bus_q[$];
  bus_exp_t mon_e;

  // UART core model knobs
  bit hold_busy = 1'b0;
  bit core_active = 1'b0;
  bit core_busy = 1'b0;
  int core_len_min = 2, core_len_max = 8;
  int dly = 0, len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [7:0] s;
    s[0] = (tx_exp_q.size() == DEPTH);
    s[1] = (tx_exp_q.size() == 0);
    s[2] = (rx_q.size() != 0);
    s[3] = (rx_q.size() == DEPTH);
    s[4] = m_ovr;
    s[5] = m_err;
    s[6] = m_ovf;
    s[7] = (tx_exp_q.size() != 0);
    return {24'h0, s};
  endfunction

  task automatic model_rx(input logic [7:0] b);
    if (rx_q.size() < DEPTH) rx_q.push_back(b);
    else m_ovr = 1'b1;
  endtask

  // One bus access; optional uart_received pulse in the same cycle as the sampled sel
  task automatic bus(input bit w, input logic [AW-1:0] a, input logic [31:0] d,
                     input bit co_rx = 1'b0, input logic [7:0] co_b = 8'h00);
    bus_exp_t e;
    int n;
    e.is_rd = !w;
    e.val   = 32'h0;
    case (a[AW-1:2])
      2'd0: begin
        if (w) begin
          if (tx_exp_q.size() < DEPTH) tx_exp_q.push_back(d[7:0]);
          else m_ovf = 1'b1;
        end else if (rx_q.size() != 0) e.val = {24'h0, rx_q.pop_front()};
      end
      2'd1: begin
        if (w) begin
          if (d[4]) m_ovr = 1'b0;
          if (d[5]) m_err = 1'b0;
          if (d[6]) m_ovf = 1'b0;
        end else e.val = m_status();
      end
      2'd2: begin
`ifdef UART_CTRL_IRQ_EN
        if (w) m_ctrl = d[2:0];
        else   e.val = {29'h0, m_ctrl};
`endif
      end
      default: ;
    endcase
    if (co_rx) model_rx(co_b);
    exp_bus_q.push_back(e);
    @(negedge clk);
    sel = 1'b1; we = w; addr = a; wdata = d;
    if (co_rx) begin uart_received = 1'b1; uart_rx_byte = co_b; end
    @(negedge clk);
    uart_received = 1'b0;
    check("ready_latency", ready, 1);
    n = 0;
    while (!ready && n < 8) begin @(negedge clk); n++; end
    @(negedge clk);
    sel = 1'b0;
    check("no_double_access", ready, 0);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    model_rx(b);
    @(negedge clk);
    uart_received = 1'b1; uart_rx_byte = b;
    @(negedge clk);
    uart_received = 1'b0;
  endtask

  task automatic rx_error();
    m_err = 1'b1;
    @(negedge clk);
    uart_recv_error = 1'b1;
    @(negedge clk);
    uart_recv_error = 1'b0;
  endtask

  task automatic wait_tx_idle();
    int n;
    n = 0;
    while ((tx_exp_q.size() != 0 || core_active || uart_is_transmitting) && n < 3000) begin
      @(negedge clk); n++;
    end
    check("tx_drain_in_time", (n < 3000), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_q.delete(); tx_exp_q.delete();
    m_ovr = 1'b0; m_err = 1'b0; m_ovf = 1'b0; m_ctrl = 3'b000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Behavioural UART core: busy after each start pulse for a random time
  initial begin
    forever begin
      @(negedge clk);
      if (core_active) begin
        if (dly > 0) dly--;
        else if (len > 0) begin core_busy = 1'b1; len--; end
        else begin core_busy = 1'b0; core_active = 1'b0; end
      end else if (uart_transmit && !rst) begin
        core_active = 1'b1;
        dly = $urandom_range(0, 2);
        len = $urandom_range(core_len_min, core_len_max);
      end
      uart_is_transmitting = core_busy | hold_busy;
    end
  end

  // Monitor: reset outputs, bus responses and UART start pulses against the queues
  logic rst_s = 1'b0;
  bit   busy_seen = 1'b0, have_prev = 1'b0;
  always @(posedge clk) rst_s <= rst;

  always @(negedge clk) begin
    if (rst_s) begin
      check("rst_ready", ready, 0);
      check("rst_rdata", rdata, 0);
      check("rst_transmit", uart_transmit, 0);
      check("rst_tx_byte", uart_tx_byte, 0);
`ifdef UART_CTRL_IRQ_EN
      check("rst_irq", irq, 0);
`endif
      have_prev = 1'b0;
    end else begin
      if (ready) begin
        if (exp_bus_q.size() == 0) begin
          total++; bad++;
          $display("FAIL bus_unexpected: ready=1 with no access pending at %0t", $time);
        end else begin
          mon_e = exp_bus_q.pop_front();
          if (mon_e.is_rd) check("bus_rdata", rdata, mon_e.val);
        end
      end else begin
        check("rdata_idle", rdata, 0);
      end
      if (uart_transmit) begin
        if (tx_exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL tx_unexpected: byte 0x%0h sent, expected none at %0t", uart_tx_byte, $time);
        end else begin
          check("tx_byte", uart_tx_byte, tx_exp_q.pop_front());
        end
        check("tx_while_busy", uart_is_transmitting, 0);
        if (have_prev) check("tx_gap_busy", busy_seen, 1);
        have_prev = 1'b1;
        busy_seen = 1'b0;
      end
    end
    if (uart_is_transmitting) busy_seen = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Post-reset state and register map basics
    bus(0, A_STATUS, 0);
    bus(0, A_DATA, 0);
    bus(1, A_CTRL, 32'h7);
    bus(0, A_CTRL, 0);
    bus(1, A_NONE, 32'hFFFF_FFFF);
    bus(0, A_NONE, 0);
    bus(1, A_CTRL, 32'h0);

    // Two bytes go out in order, second only after busy falls
    bus(1, A_DATA, 32'h41);
    bus(1, A_DATA, 32'h42);
    wait_tx_idle();
    bus(0, A_STATUS, 0);

    // Nine writes while the core is busy: full plus overflow, ninth dropped
    hold_busy = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 9; i++) bus(1, A_DATA, 32'($urandom));
    bus(0, A_STATUS, 0);
    hold_busy = 1'b0;
    wait_tx_idle();
    bus(0, A_STATUS, 0);
    bus(1, A_STATUS, 32'h40);
    bus(0, A_STATUS, 0);

    // Two received bytes read back in order
    rx_byte(8'h55);
    rx_byte(8'hAA);
    bus(0, A_DATA, 0);
    bus(0, A_DATA, 0);
    bus(0, A_STATUS, 0);

    // RX overrun, set-wins over W1C, then clear and drain
    for (int i = 0; i < 9; i++) rx_byte(8'($urandom));
    bus(0, A_STATUS, 0);
    bus(1, A_STATUS, 32'h10, 1'b1, 8'hEE);
    bus(0, A_STATUS, 0);
    bus(1, A_STATUS, 32'h10);
    bus(0, A_STATUS, 0);
    for (int i = 0; i < 8; i++) bus(0, A_DATA, 0);
    bus(0, A_DATA, 0);

    // Pop from a full RX FIFO coincident with a receive: no overrun
    for (int i = 0; i < 8; i++) rx_byte(8'(8'h10 + i));
    bus(0, A_DATA, 0, 1'b1, 8'h99);
    bus(0, A_STATUS, 0);
    for (int i = 0; i < 8; i++) bus(0, A_DATA, 0);
    bus(0, A_STATUS, 0);

    // Randomized RX-side traffic
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 7))
        0, 1: rx_byte(8'($urandom));
        2:    rx_error();
        3, 4: bus(0, A_DATA, 0, 1'($urandom_range(0, 1)), 8'($urandom));
        5:    bus(0, A_STATUS, 0);
        6:    bus(1, A_STATUS, 32'($urandom));
        default: begin
          bus(1, A_NONE, 32'($urandom));
          bus(0, A_NONE, 0);
        end
      endcase
    end
    while (rx_q.size() != 0) bus(0, A_DATA, 0);
    bus(1, A_STATUS, 32'h70);
    bus(0, A_STATUS, 0);

    // Randomized TX batches with random UART busy times
    for (int b = 0; b < 6; b++) begin
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        bus(1, A_DATA, 32'($urandom));
        repeat ($urandom_range(0, 4)) @(negedge clk);
      end
      wait_tx_idle();
      bus(0, A_STATUS, 0);
    end

`ifdef UART_CTRL_IRQ_EN
    bus(1, A_CTRL, 32'h1);
    rx_byte(8'h33);
    n = 0;
    while (irq !== 1'b1 && n < 3) begin @(negedge clk); n++; end
    check("irq_rx_set", irq, 1);
    bus(0, A_DATA, 0);
    n = 0;
    while (irq !== 1'b0 && n < 3) begin @(negedge clk); n++; end
    check("irq_rx_clear", irq, 0);
    bus(1, A_CTRL, 32'h2);
    repeat (3) @(negedge clk);
    check("irq_tx_idle", irq, 1);
    bus(1, A_CTRL, 32'h4);
    repeat (3) @(negedge clk);
    check("irq_err_quiet", irq, 0);
`endif

    // Reset while the TX FSM waits for the core to finish
    rx_byte(8'h12);
    rx_error();
`ifdef UART_CTRL_IRQ_EN
    bus(1, A_CTRL, 32'h4);
    repeat (3) @(negedge clk);
    check("irq_err_set", irq, 1);
`endif
    core_len_min = 40; core_len_max = 40;
    bus(1, A_DATA, 32'h5A);
    bus(1, A_DATA, 32'hA5);
    n = 0;
    while (!uart_is_transmitting && n < 20) begin @(negedge clk); n++; end
    check("core_busy_seen", uart_is_transmitting, 1);
    repeat (2) @(negedge clk);
    do_reset();
    core_len_min = 2; core_len_max = 8;
    wait_tx_idle();
    bus(0, A_STATUS, 0);
    bus(0, A_DATA, 0);
    bus(0, A_CTRL, 0);

    repeat (10) @(negedge clk);
    check("bus_queue_empty", exp_bus_q.size(), 0);
    check("tx_queue_empty", tx_exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
